sd_block_fetch: RTL and testbench

//  Read sequencer in front of sd_controller. On request, reads one SD block
//  via the controller's rd / dout_avail / dout_taken handshake into a local

---
 rtl/sd_block_fetch_pkg.sv | 33 +++
 rtl/sd_block_fetch_ram.sv | 44 ++++
 rtl/sd_block_fetch.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sd_block_fetch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_block_fetch_pkg.sv
// ---------------------------------------------------------------------------
// sd_block_fetch_pkg
//   Shared definitions for the SD block read sequencer: default block size,
//   default timeout, error code used for timeouts, FSM state encodings and a
//   small helper that classifies the states that wait on the SD controller.
// ---------------------------------------------------------------------------
package sd_block_fetch_pkg;

  localparam int unsigned SD_BLOCKSIZE = 512;
  localparam int unsigned SD_TIMEOUT   = 27000000;
  localparam logic [2:0]  ERR_TIMEOUT  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RDY  = 3'd1,
    ST_WAIT_BYTE = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_STREAM    = 3'd5,
    ST_DONE      = 3'd6
  } fetch_state_e;

  // States in which the SD controller can raise an error and the timeout runs.
  function automatic logic is_wait_state(input fetch_state_e st);
    logic w;
    case (st)
      ST_WAIT_RDY, ST_WAIT_BYTE, ST_WAIT_ACK, ST_DRAIN: w = 1'b1;
      default:                                          w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sd_block_fetch_ram.sv
// ---------------------------------------------------------------------------
// sd_block_fetch_ram
//   DEPTH x 8 block buffer. One write port, one synchronous read port whose
//   output register only updates when re_i is high, so a fetched byte is held
//   while the stream is stalled. Contents are not reset.
// Ports
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable (rdata_o loads mem[raddr_i] on the next edge)
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// ---------------------------------------------------------------------------
module sd_block_fetch_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Synchronous read port, holds its value when not enabled
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/sd_block_fetch.sv
// ---------------------------------------------------------------------------
// sd_block_fetch
//   Read sequencer in front of sd_controller. A req pulse in IDLE fetches one
//   SD block through the rd / dout_avail / dout_taken handshake into a local
//   buffer, then replays it as a valid/ready byte stream with out_last on the
//   final byte. SD errors and per-state timeouts end the transfer with err.
// Ports
//   clk, resetn                      clock, async active-low reset
//   req, blk_addr                    start pulse and block address
//   busy, done, err, err_code        status (done is a 1-cycle pulse)
//   sd_rd, sd_addr, sd_dout_taken    to sd_controller
//   sd_busy, sd_error, sd_error_code,
//   sd_dout, sd_dout_avail           from sd_controller
//   out_data, out_valid, out_last    stream output
//   out_ready                        stream backpressure
// ---------------------------------------------------------------------------
module sd_block_fetch
  import sd_block_fetch_pkg::*;
#(
  parameter int unsigned BLOCKSIZE = SD_BLOCKSIZE,
  parameter int unsigned TIMEOUT   = SD_TIMEOUT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] blk_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        sd_rd,
  output logic [31:0] sd_addr,
  input  logic        sd_busy,
  input  logic        sd_error,
  input  logic [2:0]  sd_error_code,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_avail,
  output logic        sd_dout_taken,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int unsigned   AW        = $clog2(BLOCKSIZE);
  localparam int unsigned   CW        = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(BLOCKSIZE);
  // The counter holds the cycles already spent in the state, so the abort
  // fires on the TIMEOUT-th cycle.
  localparam logic [31:0]   TMO_LIM   = 32'(TIMEOUT) - 32'd1;
  localparam logic [31:0]   TMO_SAT   = 32'hFFFF_FFFF;

  fetch_state_e  state_q;
  logic [CW-1:0] cnt_q;        // bytes received; one bit wider so it never wraps
  logic [CW-1:0] fetch_q;      // next buffer index to read for the stream
  logic          rvalid_q;     // RAM output register holds an unconsumed byte
  logic [31:0]   tmo_q;        // cycles spent in the current state, saturating
  logic          busy_q, done_q, err_q, sd_rd_q, sd_dout_taken_q;
  logic          out_valid_q, out_last_q;
  logic [2:0]    err_code_q;
  logic [31:0]   sd_addr_q;
  logic [7:0]    out_data_q;

  logic          in_wait_s, tmo_hit_s, abort_s;
  logic [2:0]    abort_code_s;
  logic          ram_we_s, ram_re_s, load_s, fire_s;
  logic [CW-1:0] cnt_inc_s;
  logic [7:0]    ram_rdata_s;

  // Abort detection, buffer port control and stream handshake decode
  always_comb begin
    in_wait_s    = is_wait_state(state_q);
    tmo_hit_s    = 1'b0;
    abort_s      = 1'b0;
    abort_code_s = ERR_TIMEOUT;
    ram_we_s     = 1'b0;
    ram_re_s     = 1'b0;
    cnt_inc_s    = cnt_q + CNT_ONE;
    fire_s       = out_valid_q && out_ready;
    load_s       = 1'b0;

    if (in_wait_s) begin
      tmo_hit_s = (tmo_q >= TMO_LIM);
      abort_s   = sd_error || tmo_hit_s;
    end else begin
      tmo_hit_s = 1'b0;
      abort_s   = 1'b0;
    end

    // A controller error takes precedence over a coincident timeout.
    if (sd_error) begin
      abort_code_s = sd_error_code;
    end else begin
      abort_code_s = ERR_TIMEOUT;
    end

    // An error in the same cycle as dout_avail discards the byte.
    if ((state_q == ST_WAIT_BYTE) && sd_dout_avail && !abort_s) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end

    // Output register takes the fetched byte when empty or being consumed.
    if ((state_q == ST_STREAM) && rvalid_q && (!out_valid_q || out_ready)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end

    // Byte 0 is prefetched on the DRAIN->STREAM edge; afterwards a new read
    // is issued whenever the RAM output is free or is being moved out.
    if ((state_q == ST_DRAIN) && !sd_busy && !abort_s) begin
      ram_re_s = 1'b1;
    end else if ((state_q == ST_STREAM) && (fetch_q < CNT_FULL) && (!rvalid_q || load_s)) begin
      ram_re_s = 1'b1;
    end else begin
      ram_re_s = 1'b0;
    end
  end

  sd_block_fetch_ram #(
    .DEPTH (BLOCKSIZE),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (sd_dout),
    .re_i    (ram_re_s),
    .raddr_i (fetch_q[AW-1:0]),
    .rdata_o (ram_rdata_s)
  );

  // Sequencer FSM with counters and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      cnt_q           <= CNT_ZERO;
      fetch_q         <= CNT_ZERO;
      rvalid_q        <= 1'b0;
      tmo_q           <= 32'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      err_code_q      <= 3'd0;
      sd_rd_q         <= 1'b0;
      sd_addr_q       <= 32'd0;
      sd_dout_taken_q <= 1'b0;
      out_data_q      <= 8'd0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tmo_q  <= (tmo_q == TMO_SAT) ? tmo_q : (tmo_q + 32'd1);

      if (abort_s) begin
        sd_rd_q         <= 1'b0;
        sd_dout_taken_q <= 1'b0;
        err_q           <= 1'b1;
        err_code_q      <= abort_code_s;
        state_q         <= ST_DONE;
        tmo_q           <= 32'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (req) begin
              sd_addr_q  <= blk_addr;
              busy_q     <= 1'b1;
              err_q      <= 1'b0;
              err_code_q <= 3'd0;
              fetch_q    <= CNT_ZERO;
              rvalid_q   <= 1'b0;
              state_q    <= ST_WAIT_RDY;
              tmo_q      <= 32'd0;
            end
          end
          ST_WAIT_RDY: begin
            if (!sd_busy) begin
              sd_rd_q <= 1'b1;
              cnt_q   <= CNT_ZERO;
              state_q <= ST_WAIT_BYTE;
              tmo_q   <= 32'd0;
            end
          end
          ST_WAIT_BYTE: begin
            if (sd_dout_avail) begin
              sd_dout_taken_q <= 1'b1;
              state_q         <= ST_WAIT_ACK;
              tmo_q           <= 32'd0;
            end
          end
          ST_WAIT_ACK: begin
            if (!sd_dout_avail) begin
              sd_dout_taken_q <= 1'b0;
              cnt_q           <= cnt_inc_s;
              tmo_q           <= 32'd0;
              if (cnt_inc_s < CNT_FULL) begin
                state_q <= ST_WAIT_BYTE;
              end else begin
                sd_rd_q <= 1'b0;
                state_q <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (!sd_busy) begin
              fetch_q  <= CNT_ONE;
              rvalid_q <= 1'b1;
              state_q  <= ST_STREAM;
              tmo_q    <= 32'd0;
            end
          end
          ST_STREAM: begin
            if (ram_re_s) begin
              fetch_q  <= fetch_q + CNT_ONE;
              rvalid_q <= 1'b1;
            end else if (load_s) begin
              rvalid_q <= 1'b0;
            end
            if (load_s) begin
              out_data_q  <= ram_rdata_s;
              out_valid_q <= 1'b1;
              // fetch_q already points past the byte now in the RAM register
              out_last_q  <= (fetch_q == CNT_FULL);
            end else if (fire_s) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
            if (fire_s && out_last_q) begin
              state_q <= ST_DONE;
              tmo_q   <= 32'd0;
            end
          end
          ST_DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
            tmo_q   <= 32'd0;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign sd_rd         = sd_rd_q;
  assign sd_addr       = sd_addr_q;
  assign sd_dout_taken = sd_dout_taken_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;

endmodule

// File: tb/tb_sd_block_fetch.sv
// ---------------------------------------------------------------------------
// tb_sd_block_fetch
//   Directed bench for sd_block_fetch with a behavioural sd_controller model
//   (byte i = i[7:0] ^ addr[7:0], random 1-20 cycle gaps) and a stream
//   consumer that scores every transferred byte.
// ---------------------------------------------------------------------------
module tb_sd_block_fetch;

  localparam int BS  = 512;
  localparam int TMO = 1000;

  logic        clk, resetn, req;
  logic [31:0] blk_addr;
  logic        busy, done, err;
  logic [2:0]  err_code;
  logic        sd_rd;
  logic [31:0] sd_addr;
  logic        sd_busy, sd_error;
  logic [2:0]  sd_error_code;
  logic [7:0]  sd_dout;
  logic        sd_dout_avail, sd_dout_taken;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last;

  int tests_run    = 0;
  int tests_failed = 0;

  // bench knobs and scoreboard state
  int         bfm_err_at   = -1;
  int         bfm_stall_at = -1;
  logic [2:0] bfm_err_code = 3'd0;
  int         bfm_idx      = 0;
  bit         rdy_random   = 0;
  logic [7:0] exp_addr     = 8'd0;
  int rx_cnt = 0, data_errs = 0, last_errs = 0, stall_errs = 0;
  int ov_seen = 0, done_cnt = 0;

  sd_block_fetch #(.BLOCKSIZE(BS), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .blk_addr(blk_addr),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .sd_rd(sd_rd), .sd_addr(sd_addr), .sd_busy(sd_busy), .sd_error(sd_error),
    .sd_error_code(sd_error_code), .sd_dout(sd_dout), .sd_dout_avail(sd_dout_avail),
    .sd_dout_taken(sd_dout_taken), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sd_controller model
  initial begin : bfm
    int         n;
    logic [7:0] a;
    bit         abort;
    sd_busy = 1'b0; sd_error = 1'b0; sd_error_code = 3'd0;
    sd_dout = 8'd0; sd_dout_avail = 1'b0;
    forever begin
      @(negedge clk);
      if (sd_rd && resetn) begin
        a = sd_addr[7:0];
        abort = 0;
        sd_busy = 1'b1;
        for (int i = 0; i < BS && !abort; i++) begin
          bfm_idx = i;
          repeat ($urandom_range(1, 20)) @(negedge clk);
          if (!sd_rd || !resetn) begin
            abort = 1;
          end else if (i == bfm_err_at) begin
            sd_error_code = bfm_err_code;
            sd_error = 1'b1;
            abort = 1;
          end else if (i == bfm_stall_at) begin
            abort = 1;
          end else begin
            sd_dout = 8'(i) ^ a;
            sd_dout_avail = 1'b1;
            n = 0;
            while (!sd_dout_taken && sd_rd && resetn && n < 200) begin @(negedge clk); n++; end
            sd_dout_avail = 1'b0;
            n = 0;
            while (sd_dout_taken && resetn && n < 200) begin @(negedge clk); n++; end
          end
        end
        n = 0;
        while (sd_rd && resetn && n < 5000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        sd_busy = 1'b0; sd_error = 1'b0; sd_dout_avail = 1'b0;
      end
    end
  end

  // stream consumer and scoreboard
  initial begin : consumer
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_stall = 0; prev_data = 8'd0; prev_last = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) done_cnt++;
      if (out_valid) ov_seen++;
      if (prev_stall && !(out_valid && out_data == prev_data && out_last == prev_last))
        stall_errs++;
      if (out_valid) begin
        if (out_ready) begin
          if (out_data != (8'(rx_cnt) ^ exp_addr)) data_errs++;
          if (out_last != (rx_cnt == BS - 1)) last_errs++;
          rx_cnt++;
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end else begin
        prev_stall = 0;
      end
    end
  end

  task automatic clear_score(input logic [7:0] a);
    exp_addr = a; rx_cnt = 0; data_errs = 0; last_errs = 0; stall_errs = 0;
  endtask

  task automatic start_req(input logic [31:0] a, input string tag);
    @(negedge clk);
    blk_addr = a; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check_eq({tag, "_busy"}, busy, 1'b1);
    check_eq({tag, "_sd_addr"}, sd_addr, a);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int k = 0; k < 20000; k++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic check_block(input string tag, input int dn0);
    check_eq({tag, "_count"}, rx_cnt, BS);
    check_eq({tag, "_data"}, data_errs, 0);
    check_eq({tag, "_last"}, last_errs, 0);
    check_eq({tag, "_stall"}, stall_errs, 0);
    check_eq({tag, "_err"}, {err, err_code}, 4'd0);
    check_eq({tag, "_dones"}, done_cnt - dn0, 1);
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic run_block(input logic [31:0] a, input string tag);
    bit ok;
    int dn0;
    clear_score(a[7:0]);
    dn0 = done_cnt;
    start_req(a, tag);
    wait_done(ok);
    check_eq({tag, "_done_seen"}, ok, 1'b1);
    repeat (3) @(negedge clk);
    check_block(tag, dn0);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int n, cyc, ov0, dn0;
    resetn = 1'b0; req = 1'b0; blk_addr = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {busy, done, err, sd_rd, sd_dout_taken, out_valid, out_last}, 7'd0);
    check_eq("rst_code", err_code, 3'd0);
    check_eq("rst_addr", sd_addr, 32'd0);
    check_eq("rst_data", out_data, 8'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: plain block, ready always high, 512 back-to-back valid cycles
    ov0 = ov_seen;
    run_block(32'h0000_0005, "t1");
    check_eq("t1_valid_cycles", ov_seen - ov0, BS);

    // 2: random backpressure
    rdy_random = 1;
    run_block(32'h0000_12A7, "t2");
    rdy_random = 0;

    // 3: SD error at byte 100
    bfm_err_at = 100; bfm_err_code = 3'd2;
    clear_score(8'h03);
    ov0 = ov_seen; dn0 = done_cnt;
    start_req(32'h0000_0003, "t3");
    n = 0;
    while (!sd_error && n < 5000) begin @(negedge clk); n++; end
    check_eq("t3_error_seen", sd_error, 1'b1);
    @(negedge clk);
    check_eq("t3_rd_drop", sd_rd, 1'b0);
    wait_done(ok);
    check_eq("t3_done_seen", ok, 1'b1);
    check_eq("t3_err", {err, err_code}, 4'b1010);
    repeat (10) @(negedge clk);
    check_eq("t3_no_stream", ov_seen - ov0, 0);
    check_eq("t3_dones", done_cnt - dn0, 1);
    bfm_err_at = -1;

    // 4: controller stalls, timeout then clean recovery
    bfm_stall_at = 0;
    start_req(32'h0000_0007, "t4");
    n = 0;
    while (!sd_rd && n < 100) begin @(negedge clk); n++; end
    check_eq("t4_rd_seen", sd_rd, 1'b1);
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    check_eq("t4_tmo_window", (cyc >= 999 && cyc <= 1003), 1'b1);
    check_eq("t4_err", {err, err_code}, 4'b1111);
    bfm_stall_at = -1;
    repeat (10) @(negedge clk);
    run_block(32'h0000_0022, "t4b");

    // 5: async reset in the middle of the fetch
    bfm_idx = 0;
    start_req(32'h0000_0040, "t5");
    n = 0;
    while (bfm_idx < 300 && n < 10000) begin @(negedge clk); n++; end
    check_eq("t5_reached_300", bfm_idx >= 300, 1'b1);
    resetn = 1'b0;
    #1;
    check_eq("t5_rst_drop", {sd_rd, busy, sd_dout_taken}, 3'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    run_block(32'h0000_0009, "t5b");

    // 6: req held and repeated while busy -> one transfer
    clear_score(8'h6C);
    dn0 = done_cnt;
    @(negedge clk);
    blk_addr = 32'h0000_006C; req = 1'b1;
    repeat (40) @(negedge clk);
    blk_addr = 32'h0000_00FF;
    for (int k = 0; k < 3; k++) begin
      req = 1'b0;
      repeat (100) @(negedge clk);
      req = 1'b1;
      @(negedge clk);
    end
    req = 1'b0;
    wait_done(ok);
    check_eq("t6_done_seen", ok, 1'b1);
    check_eq("t6_addr", sd_addr, 32'h0000_006C);
    repeat (30) @(negedge clk);
    check_block("t6", dn0);
    run_block(32'h0000_0011, "t6b");
    run_block(32'h0000_0012, "t6c");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
